// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and types shared by the CNN layer blocks.
//   DATA_WIDTH     signed feature-map word width (conv, pool, tx).
//   FRAME_SIZE_L1  words in one layer-1 output frame (2 x 24 x 24).
//   ADDR_W_L1      address/counter width for a layer-1 frame.
//   tx_state_t     stream transmitter FSM state.
package cnn_pkg;
  localparam int DATA_WIDTH    = 16;
  localparam int IMG_SIZE_L1   = 24;
  localparam int CHANNELS_L1   = 2;
  localparam int FRAME_SIZE_L1 = CHANNELS_L1 * IMG_SIZE_L1 * IMG_SIZE_L1;
  localparam int ADDR_W_L1     = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } tx_state_t;

  // Words per frame for a given channel count and square side length.
  function automatic int frame_words(input int ch, input int side);
    return ch * side * side;
  endfunction
endpackage

// File: rtl/fmap_stream_tx_if.sv
// fmap_stream_tx_if: write bus from the conv engine plus the stream bus
// towards the pooling stage.
//   wr_en/wr_addr/wr_data  buffer write port (addr = ch*S*S + row*S + col)
//   frame_done             frame complete, start transmission
//   hold                   downstream pause request
//   tx_start/tx_valid/tx_data/tx_done  stream to the pooling stage
//   busy                   transmitter not idle
// master = producer/consumer side (conv engine + pool), slave = transmitter.
interface fmap_stream_tx_if #(
  parameter int ADDR_W     = cnn_pkg::ADDR_W_L1,
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH
);
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic signed [DATA_WIDTH-1:0] wr_data;
  logic                         frame_done;
  logic                         hold;
  logic                         tx_start;
  logic                         tx_valid;
  logic signed [DATA_WIDTH-1:0] tx_data;
  logic                         tx_done;
  logic                         busy;

  modport master (
    output wr_en, wr_addr, wr_data, frame_done, hold,
    input  tx_start, tx_valid, tx_data, tx_done, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, frame_done, hold,
    output tx_start, tx_valid, tx_data, tx_done, busy
  );
endinterface

// File: rtl/fmap_stream_tx_ram.sv
// fmap_ram: simple dual-port frame buffer, one write port and one
// synchronous read port with a registered output. No reset so it maps
// onto block RAM.
//   clk              clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddr          read address, data appears on o_rdata after one edge
//   o_rdata          registered read data
module fmap_ram #(
  parameter int DEPTH      = cnn_pkg::FRAME_SIZE_L1,
  parameter int ADDR_W     = cnn_pkg::ADDR_W_L1,
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic signed [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]            i_raddr,
  output logic signed [DATA_WIDTH-1:0] o_rdata
);
  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: buffers one conv output frame written by address, then on
// frame_done emits a tx_start pulse and streams the frame in ascending
// address order (channel-major, row-major) with hold backpressure, followed
// by a tx_done pulse.
//   clk, reset_n  clock, synchronous active-low reset
//   bus (slave)   write port, frame_done, hold in; tx_* and busy out
module fmap_stream_tx #(
  parameter int IMG_SIZE   = cnn_pkg::IMG_SIZE_L1,
  parameter int CHANNELS   = cnn_pkg::CHANNELS_L1,
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int ADDR_W     = cnn_pkg::ADDR_W_L1
) (
  input  logic clk,
  input  logic reset_n,
  fmap_stream_tx_if.slave bus
);
  import cnn_pkg::*;

  localparam int              FRAME   = frame_words(CHANNELS, IMG_SIZE);
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FRAME - 1);

  tx_state_t                    r_state;
  logic [ADDR_W-1:0]            r_cnt;
  logic                         r_last;   // final word is on the bus
  logic                         r_tx_start;
  logic                         r_tx_valid;
  logic signed [DATA_WIDTH-1:0] r_tx_data;
  logic                         r_tx_done;
  logic                         r_busy;

  logic                         w_we;
  logic [ADDR_W-1:0]            w_raddr;
  logic signed [DATA_WIDTH-1:0] w_rdata;

  // Buffer is only writable while idle; out-of-frame addresses are dropped.
  assign w_we = reset_n && (r_state == IDLE) && bus.wr_en && (bus.wr_addr < FRAME_A);

  // RAM output must hold word[k] whenever k is the next word to present.
  // START primes word 0; an accepted word prefetches k+1, a held cycle
  // re-reads k so the prefetched word survives the stall.
  always_comb begin
    w_raddr = '0;
    if (r_state == STREAM && !r_last)
      w_raddr = (bus.hold || r_cnt == LAST_A) ? r_cnt : r_cnt + 1'b1;
  end

  fmap_ram #(
    .DEPTH      (FRAME),
    .ADDR_W     (ADDR_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.wr_addr),
    .i_wdata (bus.wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_tx_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.frame_done) begin
            r_state    <= START;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_last  <= 1'b0;
          r_state <= STREAM;
        end
        STREAM: begin
          // One extra STREAM edge after the last word lets tx_done land in
          // the cycle following the final valid, with busy still high.
          if (r_last) begin
            r_tx_valid <= 1'b0;
            r_tx_done  <= 1'b1;
            r_state    <= DONE;
          end else if (bus.hold) begin
            r_tx_valid <= 1'b0;
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_rdata;
            if (r_cnt == LAST_A) r_last <= 1'b1;
            else                 r_cnt  <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_start = r_tx_start;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_done  = r_tx_done;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_fmap_stream_tx.sv
// Self-checking bench for fmap_stream_tx: a plain array mirrors the frame
// buffer and the expected stream is simply that array in address order.
module tb_fmap_stream_tx;
  localparam int FRAME = 1152;
  localparam int AW    = 11;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fmap_stream_tx_if #(.ADDR_W(AW), .DATA_WIDTH(DW)) bus ();

  fmap_stream_tx #(
    .IMG_SIZE(24), .CHANNELS(2), .DATA_WIDTH(DW), .ADDR_W(AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] model [FRAME];
  logic [DW-1:0] exp_data;   // value tx_data should be holding
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
    if (addr < FRAME) model[addr] = data;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_data"},  {16'h0, bus.tx_data}, {16'h0, exp_data});
    check({tag, "_done"},  32'(bus.tx_done), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  // Starts a frame from the current sample point and checks it through to
  // busy dropping. hmode: 0 no hold, 1 directed+random hold. noise: drive
  // writes to address 0 and frame_done during the stream. rst_after >= 0
  // truncates the stream by reset once that word index has been seen.
  task automatic run_frame(input int hmode, input bit noise, input int rst_after);
    int got = 0;
    int cyc = 0;
    int dones = 0;
    bit h;
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    bus.wr_en      = 1'b0;
    check("start_pulse", 32'(bus.tx_start), 32'd1);
    check("start_busy",  32'(bus.busy),     32'd1);
    check("start_valid", 32'(bus.tx_valid), 32'd0);
    bus.hold = (hmode != 0);   // must not matter during START
    tick();
    check("start_one_cycle", 32'(bus.tx_start), 32'd0);
    check("stream_pre_valid", 32'(bus.tx_valid), 32'd0);
    while (got < FRAME && cyc < 4 * FRAME) begin
      h = 1'b0;
      if (hmode != 0)
        h = (cyc >= 10 && cyc <= 14) || (got >= 500 && got <= 520 && cyc[0])
            || ($urandom_range(0, 7) == 0);
      bus.hold = h;
      if (noise) begin
        bus.wr_en      = 1'b1;
        bus.wr_addr    = '0;
        bus.wr_data    = DW'($urandom);
        bus.frame_done = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
      if (bus.tx_done) dones++;
      if (h) begin
        check("held_valid", 32'(bus.tx_valid), 32'd0);
        check("held_stable", {16'h0, bus.tx_data}, {16'h0, exp_data});
      end else begin
        exp_data = model[got];
        check("word_valid", 32'(bus.tx_valid), 32'd1);
        check("word_data", {16'h0, bus.tx_data}, {16'h0, exp_data});
        got++;
      end
      if (rst_after >= 0 && got == rst_after + 1) begin
        bus.hold = 1'b0; bus.wr_en = 1'b0; bus.frame_done = 1'b0;
        reset_n  = 1'b0;
        tick();
        exp_data = '0;
        check_idle_outputs("midrst");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          check("midrst_no_done", 32'(bus.tx_done), 32'd0);
          check("midrst_idle",    32'(bus.busy),    32'd0);
        end
        return;
      end
    end
    check("stream_complete", 32'(got), 32'(FRAME));
    check("no_early_done", 32'(dones), 32'd0);
    bus.wr_en = 1'b0; bus.frame_done = 1'b0;
    bus.hold  = 1'($urandom_range(0, 1));
    tick();
    check("done_pulse", 32'(bus.tx_done), 32'd1);
    check("done_valid", 32'(bus.tx_valid), 32'd0);
    check("done_busy",  32'(bus.busy),     32'd1);
    bus.hold = 1'b0;
    tick();
    check("done_one_cycle", 32'(bus.tx_done), 32'd0);
    check("busy_drop",      32'(bus.busy),    32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.frame_done = 1'b0;
    bus.hold       = 1'b0;
    exp_data       = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Basic frame: ramp -576..575, no backpressure.
    for (int i = 0; i < FRAME; i++) wr(i, DW'(i - 576));
    run_frame(0, 1'b0, -1);

    // Back-to-back re-arm in the first idle cycle, with directed+random hold.
    run_frame(1, 1'b0, -1);

    // Random rewrites, illegal addresses, then a frame with bus noise.
    for (int i = 0; i < 200; i++) wr($urandom_range(0, FRAME - 1), DW'($urandom));
    wr(FRAME, 16'h7FFF);
    for (int i = 0; i < 4; i++) wr($urandom_range(FRAME, 2047), 16'h7FFF);
    run_frame(1, 1'b1, -1);
    // Address 0 must still hold its pre-frame value.
    run_frame(0, 1'b0, -1);
    check("addr0_frozen", {16'h0, model[0]}, {16'h0, exp_data == model[FRAME-1] ? model[0] : 16'hDEAD});

    // Write coinciding with frame_done lands in the transmitted frame.
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(FRAME - 1);
    bus.wr_data = 16'h1234;
    model[FRAME-1] = 16'h1234;
    run_frame(0, 1'b0, -1);
    check("same_cycle_last_word", {16'h0, exp_data}, 32'h1234);

    // Reset after word 300, then a full retransmission from word 0.
    run_frame(0, 1'b0, 300);
    run_frame(1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
